// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline stages: datapath widths and the
// write-back control bundle carried through the MEM/WB register.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    // Control fields that travel with an instruction into write-back.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    // A memory access is misaligned when the byte offset is non-zero
    // and the instruction actually touches memory.
    function automatic logic is_misaligned(input logic [1:0] byte_off,
                                           input logic       mem_write,
                                           input logic       mem_read);
        return (byte_off != 2'b00) & (mem_write | mem_read);
    endfunction

endpackage

// File: rtl/stage4_mem_if.sv
// Bundle of the EX/MEM inputs, pipeline controls and MEM/WB outputs of the
// MEM stage. The master side drives the M-stage signals, the slave is the stage.
interface stage4_mem_if;
    import mips_pkg::*;

    logic [WORD_W-1:0] AluoutM;
    logic [WORD_W-1:0] writeDataM;
    logic [REG_W-1:0]  writeRegM;
    logic              RegWriteM;
    logic              MemtoRegM;
    logic              MemwriteM;
    logic              StallM;
    logic              FlushW;

    logic [WORD_W-1:0] ReadDataW;
    logic [WORD_W-1:0] AluoutW;
    logic [REG_W-1:0]  writeRegW;
    logic              RegWriteW;
    logic              MemtoRegW;
    logic [WORD_W-1:0] ResultW;
    logic              AlignErr;

    modport master (
        output AluoutM, writeDataM, writeRegM, RegWriteM, MemtoRegM,
               MemwriteM, StallM, FlushW,
        input  ReadDataW, AluoutW, writeRegW, RegWriteW, MemtoRegW,
               ResultW, AlignErr
    );

    modport slave (
        input  AluoutM, writeDataM, writeRegM, RegWriteM, MemtoRegM,
               MemwriteM, StallM, FlushW,
        output ReadDataW, AluoutW, writeRegW, RegWriteW, MemtoRegW,
               ResultW, AlignErr
    );

endinterface

// File: rtl/stage4_mem_data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read.
// Contents are not reset; they start at zero.
module data_mem
    import mips_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wd,
    output logic [WORD_W-1:0] rd
);

    logic [WORD_W-1:0] mem_r [DEPTH] = '{default: '0};

    // Store the write data into the addressed word when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wd;
        end
    end

    // Read port returns the current (pre-write) contents.
    assign rd = mem_r[addr];

endmodule

// File: rtl/stage4_mem.sv
// MEM stage and MEM/WB pipeline register with stall, flush and a sticky
// misaligned-access flag. Misaligned stores are dropped and misaligned loads
// lose their register write-back.
module stage4_mem
    import mips_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic         clk,
    input  logic         Rst,
    stage4_mem_if.slave  bus
);

    logic [ADDR_W-1:0] mem_addr_s;
    logic [WORD_W-1:0] mem_rd_s;
    logic              misaligned_s;
    logic              mem_we_s;
    wb_ctrl_t          wb_ctrl_s;

    logic [WORD_W-1:0] read_data_r;
    logic [WORD_W-1:0] aluout_r;
    logic [REG_W-1:0]  write_reg_r;
    wb_ctrl_t          wb_ctrl_r;
    logic              align_err_r;

    // Upper address bits are ignored, so addresses alias modulo DEPTH words.
    assign mem_addr_s   = bus.AluoutM[ADDR_W+1:2];
    assign misaligned_s = is_misaligned(bus.AluoutM[1:0], bus.MemwriteM, bus.MemtoRegM);
    // A store coinciding with reset is dropped, as are stalled or misaligned ones.
    assign mem_we_s     = bus.MemwriteM & ~bus.StallM & ~misaligned_s & ~Rst;

    data_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk  (clk),
        .we   (mem_we_s),
        .addr (mem_addr_s),
        .wd   (bus.writeDataM),
        .rd   (mem_rd_s)
    );

    // Control bundle to capture; a misaligned load never writes back.
    always_comb begin
        wb_ctrl_s.mem_to_reg = bus.MemtoRegM;
        if (misaligned_s & bus.MemtoRegM) begin
            wb_ctrl_s.reg_write = 1'b0;
        end else begin
            wb_ctrl_s.reg_write = bus.RegWriteM;
        end
    end

    // MEM/WB register: flush beats stall, stall holds, otherwise capture.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            read_data_r <= {WORD_W{1'b0}};
            aluout_r    <= {WORD_W{1'b0}};
            write_reg_r <= {REG_W{1'b0}};
            wb_ctrl_r   <= '{reg_write: 1'b0, mem_to_reg: 1'b0};
        end else if (bus.FlushW) begin
            read_data_r <= {WORD_W{1'b0}};
            aluout_r    <= {WORD_W{1'b0}};
            write_reg_r <= {REG_W{1'b0}};
            wb_ctrl_r   <= '{reg_write: 1'b0, mem_to_reg: 1'b0};
        end else if (bus.StallM) begin
            read_data_r <= read_data_r;
            aluout_r    <= aluout_r;
            write_reg_r <= write_reg_r;
            wb_ctrl_r   <= wb_ctrl_r;
        end else begin
            read_data_r <= mem_rd_s;
            aluout_r    <= bus.AluoutM;
            write_reg_r <= bus.writeRegM;
            wb_ctrl_r   <= wb_ctrl_s;
        end
    end

    // Sticky misaligned flag; only reset clears it, flush does not.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            align_err_r <= 1'b0;
        end else if (misaligned_s & ~bus.StallM) begin
            align_err_r <= 1'b1;
        end else begin
            align_err_r <= align_err_r;
        end
    end

    assign bus.ReadDataW = read_data_r;
    assign bus.AluoutW   = aluout_r;
    assign bus.writeRegW = write_reg_r;
    assign bus.RegWriteW = wb_ctrl_r.reg_write;
    assign bus.MemtoRegW = wb_ctrl_r.mem_to_reg;
    assign bus.AlignErr  = align_err_r;
    assign bus.ResultW   = wb_ctrl_r.mem_to_reg ? read_data_r : aluout_r;

endmodule

// File: tb/tb_stage4_mem.sv
// Directed self-checking bench for stage4_mem.
module tb_stage4_mem;

    logic clk;
    logic Rst;
    int   n_vec;
    int   n_miscomp;

    stage4_mem_if bus ();

    stage4_mem #(
        .DEPTH  (64),
        .ADDR_W (6)
    ) dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscomp++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] wreg, input logic regw,
                         input logic m2r, input logic memw);
        bus.AluoutM    = alu;
        bus.writeDataM = wd;
        bus.writeRegM  = wreg;
        bus.RegWriteM  = regw;
        bus.MemtoRegM  = m2r;
        bus.MemwriteM  = memw;
    endtask

    task automatic check_w_zero(input string tag);
        check_value({tag, "_rd"},   bus.ReadDataW, 32'h0);
        check_value({tag, "_alu"},  bus.AluoutW, 32'h0);
        check_value({tag, "_wreg"}, {27'h0, bus.writeRegW}, 32'h0);
        check_value({tag, "_regw"}, {31'h0, bus.RegWriteW}, 32'h0);
        check_value({tag, "_m2r"},  {31'h0, bus.MemtoRegW}, 32'h0);
        check_value({tag, "_res"},  bus.ResultW, 32'h0);
    endtask

    initial begin
        n_vec     = 0;
        n_miscomp = 0;
        Rst       = 1'b1;
        bus.StallM = 1'b0;
        bus.FlushW = 1'b0;
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        #12;
        check_w_zero("reset");
        check_value("reset_aerr", {31'h0, bus.AlignErr}, 32'h0);
        Rst = 1'b0;
        #1;

        // ALU passthrough
        drive(32'h0000002A, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        check_value("alu_aluw", bus.AluoutW, 32'h2A);
        check_value("alu_res",  bus.ResultW, 32'h2A);
        check_value("alu_regw", {31'h0, bus.RegWriteW}, 32'h1);
        check_value("alu_wreg", {27'h0, bus.writeRegW}, 32'd3);

        // Store then load
        drive(32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        check_value("sw_regw", {31'h0, bus.RegWriteW}, 32'h0);
        drive(32'h10, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0);
        tick();
        check_value("lw_rd",   bus.ReadDataW, 32'hDEADBEEF);
        check_value("lw_res",  bus.ResultW, 32'hDEADBEEF);
        check_value("lw_wreg", {27'h0, bus.writeRegW}, 32'd8);
        check_value("lw_regw", {31'h0, bus.RegWriteW}, 32'h1);

        // Aliasing: 0x100 maps to word 0
        drive(32'h100, 32'h12345678, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(32'h000, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
        tick();
        check_value("alias_rd", bus.ReadDataW, 32'h12345678);
        check_value("alias_aerr", {31'h0, bus.AlignErr}, 32'h0);

        // Misaligned store: suppressed, flag set
        drive(32'h13, 32'hAAAAAAAA, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        check_value("mis_sw_aerr", {31'h0, bus.AlignErr}, 32'h1);
        drive(32'h10, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0);
        tick();
        check_value("mis_sw_word4", bus.ReadDataW, 32'hDEADBEEF);

        // Misaligned load: no write-back, flag stays
        drive(32'h22, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        check_value("mis_lw_regw", {31'h0, bus.RegWriteW}, 32'h0);
        check_value("mis_lw_aerr", {31'h0, bus.AlignErr}, 32'h1);

        // Stall for two cycles with a pending store
        drive(32'h55, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        bus.StallM = 1'b1;
        drive(32'h20, 32'h11111111, 5'd2, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_value("stall_alu",  bus.AluoutW, 32'h55);
            check_value("stall_wreg", {27'h0, bus.writeRegW}, 32'd7);
            check_value("stall_regw", {31'h0, bus.RegWriteW}, 32'h1);
        end
        bus.StallM = 1'b0;
        drive(32'h20, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
        tick();
        check_value("stall_nowrite", bus.ReadDataW, 32'h0);
        check_value("stall_wreg4", {27'h0, bus.writeRegW}, 32'd4);

        // Flush wins over stall; flag survives flush
        bus.StallM = 1'b1;
        bus.FlushW = 1'b1;
        tick();
        check_w_zero("flush");
        check_value("flush_aerr", {31'h0, bus.AlignErr}, 32'h1);
        bus.StallM = 1'b0;
        bus.FlushW = 1'b0;

        // Illegal load+store same word: read sees old data, write happens
        drive(32'h10, 32'hCAFEF00D, 5'd6, 1'b1, 1'b1, 1'b1);
        tick();
        check_value("rw_old", bus.ReadDataW, 32'hDEADBEEF);
        drive(32'h10, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0);
        tick();
        check_value("rw_new", bus.ReadDataW, 32'hCAFEF00D);

        // Asynchronous reset mid-stream
        drive(32'h77, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        check_value("pre_rst_regw", {31'h0, bus.RegWriteW}, 32'h1);
        #2;
        Rst = 1'b1;
        #1;
        check_w_zero("async_rst");
        check_value("async_rst_aerr", {31'h0, bus.AlignErr}, 32'h0);

        // Store coinciding with reset is dropped
        drive(32'h30, 32'h77777777, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        Rst = 1'b0;
        drive(32'h30, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0);
        tick();
        check_value("rst_store_dropped", bus.ReadDataW, 32'h0);
        check_value("rst_store_wreg", {27'h0, bus.writeRegW}, 32'd10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
        $finish;
    end

endmodule
